// File: rtl/multi_buf.sv
// First-word-fall-through N-entry packet FIFO with occupancy, almost-full, flush and sticky error flags.
// Latency: write visible on dout one cycle later; rd accepted while full frees the slot for a same-cycle write.
module multi_buf #(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  vld,
    output logic                  full,
    output logic                  afull,
    output logic [CNT_W-1:0]      count,
    output logic                  ovfl,
    output logic                  udfl
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovfl_q, ovfl_d;
    logic                  udfl_q, udfl_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status comes only from registered count, never from wr/rd.
    assign vld   = (count_q != '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign afull = (count_q >= CNT_W'(AFULL_THRESH));
    assign count = count_q;
    assign ovfl  = ovfl_q;
    assign udfl  = udfl_q;
    assign dout  = vld ? mem_q[rd_ptr_q] : '0;

    assign push = wr & ~flush & (~full | rd);
    assign pop  = rd & ~flush & vld;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovfl_d   = ovfl_q;
        udfl_d   = udfl_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovfl_d   = 1'b0;
            udfl_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (wr && full && !rd) ovfl_d = 1'b1;
            if (rd && !vld)        udfl_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovfl_q   <= 1'b0;
            udfl_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovfl_q   <= ovfl_d;
            udfl_q   <= udfl_d;
        end
    end

    // Storage is left unreset; dout is gated by vld instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: tb/tb_multi_buf.sv
// Scoreboard bench for multi_buf (DEPTH=4, DATA_WIDTH=128, AFULL_THRESH=3).
module tb_multi_buf;

    logic         clk;
    logic         rst_l;
    logic         flush;
    logic         wr;
    logic [127:0] din;
    logic         rd;
    logic [127:0] dout;
    logic         vld;
    logic         full;
    logic         afull;
    logic [2:0]   count;
    logic         ovfl;
    logic         udfl;

    int n_cmp = 0;
    int n_err = 0;
    int mcnt  = 0;
    logic [127:0] exp_q [$];

    multi_buf dut (
        .clk   (clk),
        .rst_l (rst_l),
        .flush (flush),
        .wr    (wr),
        .din   (din),
        .rd    (rd),
        .dout  (dout),
        .vld   (vld),
        .full  (full),
        .afull (afull),
        .count (count),
        .ovfl  (ovfl),
        .udfl  (udfl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] pat(input int i);
        return {4{32'hD000_0000 + 32'(i)}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; the expected acceptance is decided from the bench's own count.
    task automatic step(input logic w, input logic [127:0] d, input logic r, input logic f);
        bit p;
        bit q;
        wr = w; din = d; rd = r; flush = f;
        if (f) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            p = w && (mcnt < 4 || r);
            q = r && (mcnt > 0);
            if (p) exp_q.push_back(d);
            mcnt = mcnt + int'(p) - int'(q);
        end
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0;
    endtask

    // Monitor: every pop the DUT will take at the coming edge must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_l && !flush && rd && vld) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected none", dout);
            end else begin
                chk("pop_data", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_l = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        #12;
        chk("rst_count", 128'(count), 0);
        chk("rst_vld",   128'(vld),   0);
        chk("rst_full",  128'(full),  0);
        chk("rst_afull", 128'(afull), 0);
        chk("rst_ovfl",  128'(ovfl),  0);
        chk("rst_udfl",  128'(udfl),  0);
        chk("rst_dout",  dout,        0);
        @(posedge clk); #1;
        rst_l = 1'b1;

        // Single write, then read back.
        step(1'b1, {16{8'hA5}}, 1'b0, 1'b0);
        chk("w1_vld",   128'(vld),   1);
        chk("w1_count", 128'(count), 1);
        chk("w1_afull", 128'(afull), 0);
        chk("w1_dout",  dout, {16{8'hA5}});
        step(1'b0, '0, 1'b1, 1'b0);
        chk("r1_vld",  128'(vld), 0);
        chk("r1_dout", dout, 0);

        // Fill to full, check thresholds, overflow drop.
        step(1'b1, pat(0), 1'b0, 1'b0);
        step(1'b1, pat(1), 1'b0, 1'b0);
        chk("c2_afull", 128'(afull), 0);
        step(1'b1, pat(2), 1'b0, 1'b0);
        chk("c3_afull", 128'(afull), 1);
        chk("c3_full",  128'(full),  0);
        step(1'b1, pat(3), 1'b0, 1'b0);
        chk("c4_full",  128'(full),  1);
        chk("c4_count", 128'(count), 4);
        step(1'b1, pat(9), 1'b0, 1'b0);
        chk("ov_flag",  128'(ovfl),  1);
        chk("ov_count", 128'(count), 4);
        chk("ov_head",  dout, pat(0));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_vld",   128'(vld),   0);
        chk("drain_count", 128'(count), 0);
        chk("ov_sticky",   128'(ovfl),  1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("fl_ovfl", 128'(ovfl), 0);

        // Full buffer with simultaneous write+read, long enough to wrap pointers.
        for (int i = 0; i < 4; i++) step(1'b1, pat(10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, pat(20 + i), 1'b1, 1'b0);
            chk("wr_rd_count", 128'(count), 4);
            if (i == 0) chk("wr_rd_head", dout, pat(11));
        end
        chk("wr_rd_ovfl", 128'(ovfl), 0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_vld", 128'(vld), 0);

        // Underflow, then write+read on empty: write is taken, no pop.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ud_flag",  128'(udfl),  1);
        chk("ud_count", 128'(count), 0);
        step(1'b1, pat(40), 1'b1, 1'b0);
        chk("ud_wr_count", 128'(count), 1);
        chk("ud_wr_dout",  dout, pat(40));
        for (int i = 1; i < 4; i++) step(1'b1, pat(40 + i), 1'b0, 1'b0);
        step(1'b1, pat(49), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_fl_count", 128'(count), 3);
        chk("pre_fl_ovfl",  128'(ovfl),  1);
        chk("pre_fl_udfl",  128'(udfl),  1);

        // Flush beats a concurrent write.
        step(1'b1, pat(50), 1'b0, 1'b1);
        chk("fl_count", 128'(count), 0);
        chk("fl_vld",   128'(vld),   0);
        chk("fl_ovfl2", 128'(ovfl),  0);
        chk("fl_udfl",  128'(udfl),  0);
        chk("fl_dout",  dout, 0);

        // Async reset mid-burst.
        step(1'b1, pat(60), 1'b0, 1'b0);
        step(1'b1, pat(61), 1'b0, 1'b0);
        chk("mr_pre_count", 128'(count), 2);
        wr = 1'b1; din = pat(62);
        #2;
        rst_l = 1'b0;
        #1;
        chk("mr_count", 128'(count), 0);
        chk("mr_vld",   128'(vld),   0);
        chk("mr_dout",  dout, 0);
        exp_q.delete();
        mcnt = 0;
        wr = 1'b0;
        @(posedge clk); #1;
        rst_l = 1'b1;
        step(1'b1, pat(70), 1'b0, 1'b0);
        chk("post_rst_dout", dout, pat(70));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("queue_drained", 128'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
